// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle signed DIV/MOD unit with a valid/ready handshake.
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by a single sign fix-up cycle. Results truncate toward zero and
// the remainder carries the dividend's sign.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; operands and flags latched on accept
// ITERATE | one restoring-division step per clock, DataWidth steps
// FIXUP   | apply signs / divide-by-zero rules, load the result
// HOLD    | result presented until the consumer takes it
//
// OutValid is registered off HOLD, so it rises on the second HOLD edge.
// That gives a fixed DataWidth+2 edge latency from the accepting edge.
module seq_div_unit #(
  parameter int                  DataWidth = 16,
  parameter int                  OpWidth   = 4,
  parameter logic [OpWidth-1:0]  OpMod     = OpWidth'(7)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [OpWidth-1:0]    Operation,
  input  logic [DataWidth-1:0]  InDest,
  input  logic [DataWidth-1:0]  InSrc,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [DataWidth-1:0]  OutDest,
  output logic                  DivZero,
  output logic                  OutValid,
  input  logic                  OutReady
);

  localparam int W1   = DataWidth + 1;
  localparam int CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    FIXUP   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  // Holds the dividend magnitude; quotient bits shift in from the bottom
  // as dividend bits shift out of the top.
  logic [DataWidth-1:0]   quo_q, quo_d;
  logic [W1-1:0]          rem_q, rem_d;
  logic [W1-1:0]          dvs_q, dvs_d;
  logic                   is_mod_q, is_mod_d;
  logic                   neg_a_q, neg_a_d;
  logic                   neg_b_q, neg_b_d;
  logic                   dz_q, dz_d;
  logic [DataWidth-1:0]   out_dest_q, out_dest_d;
  logic                   div_zero_q, div_zero_d;
  logic                   out_valid_q, out_valid_d;

  logic [DataWidth-1:0]   dest_mag;
  logic [W1-1:0]          src_ext;
  logic [W1-1:0]          src_mag;
  logic [W1:0]            shifted;
  logic [W1:0]            diff;
  logic [DataWidth-1:0]   r_mag;
  logic [DataWidth-1:0]   q_fix;
  logic [DataWidth-1:0]   r_fix;

  // Operand magnitudes, trial subtraction and sign fix-up values
  always_comb begin
    // Unsigned DataWidth bits already hold 2^(DataWidth-1) for the dividend.
    dest_mag = InDest[DataWidth-1] ? -InDest : InDest;
    src_ext  = {InSrc[DataWidth-1], InSrc};
    src_mag  = InSrc[DataWidth-1] ? -src_ext : src_ext;
    shifted  = {rem_q, quo_q[DataWidth-1]};
    diff     = shifted - {1'b0, dvs_q};
    r_mag    = rem_q[DataWidth-1:0];
    if (dz_q) begin
      q_fix = '1;
    end else if (neg_a_q ^ neg_b_q) begin
      q_fix = -quo_q;
    end else begin
      q_fix = quo_q;
    end
    // With a zero divisor every step succeeds, so the remainder magnitude
    // equals |dividend| and this path restores the original dividend.
    r_fix = neg_a_q ? -r_mag : r_mag;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    is_mod_d    = is_mod_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    dz_d        = dz_q;
    out_dest_d  = out_dest_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          is_mod_d = (Operation == OpMod);
          neg_a_d  = InDest[DataWidth-1];
          neg_b_d  = InSrc[DataWidth-1];
          quo_d    = dest_mag;
          dvs_d    = src_mag;
          rem_d    = '0;
          dz_d     = (InSrc == '0);
          cnt_d    = CntW'(DataWidth - 1);
          state_d  = ITERATE;
        end
      end
      ITERATE: begin
        if (!diff[W1]) begin
          rem_d = diff[W1-1:0];
        end else begin
          rem_d = shifted[W1-1:0];
        end
        quo_d = {quo_q[DataWidth-2:0], ~diff[W1]};
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      FIXUP: begin
        out_dest_d = is_mod_q ? r_fix : q_fix;
        div_zero_d = dz_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      is_mod_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      dz_q        <= 1'b0;
      out_dest_q  <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      is_mod_q    <= is_mod_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      dz_q        <= dz_d;
      out_dest_q  <= out_dest_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutDest  = out_dest_q;
  assign DivZero  = div_zero_q;
  assign OutValid = out_valid_q;

endmodule
